// File: rtl/csr_counter_window_pkg.sv
// csr_counter_window_pkg
// Shared definitions for the counter-window CSR controller.
//   - CWC_CNT_BITS      : width of the application event counters
//   - OP_*              : command opcodes carried in wr_data[7:0]
//   - t_cwc_state       : controller state encoding
//   - ST_*              : bit positions inside the 64-bit status word
package csr_counter_window_pkg;

   localparam int CWC_CNT_BITS = 40;

   localparam logic [7:0] OP_SNAP    = 8'h01;
   localparam logic [7:0] OP_CLEAR   = 8'h02;
   localparam logic [7:0] OP_SET_WIN = 8'h03;
   localparam logic [7:0] OP_CLR_ERR = 8'h04;

   typedef enum logic [1:0] {
      CWC_IDLE     = 2'd0,
      CWC_SNAP     = 2'd1,
      CWC_CLR_WAIT = 2'd2
   } t_cwc_state;

   localparam int ST_BUSY        = 0;
   localparam int ST_ERR_DROP    = 1;
   localparam int ST_ERR_BADOP   = 2;
   localparam int ST_ERR_BADBASE = 3;
   localparam int ST_BASE_LSB    = 8;
   localparam int ST_SEQ_LSB     = 16;
   localparam int ST_TS_LSB      = 32;

endpackage

// File: rtl/csr_counter_window_mux.sv
// csr_counter_window_mux
// Holds the window base register and the registered read-CSR window.
// Slot w shows snapshot entry base+w zero-extended to 64 bits, or 0 when
// base+w falls past the last counter.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   base_we_i      : load base_wdata_i into the base register
//   base_wdata_i   : new base (already range-checked by the caller)
//   snap_i         : flattened snapshot bank
//   base_o         : current base register
//   win_data_o     : WINDOW x 64-bit registered window
module csr_counter_window_mux
   import csr_counter_window_pkg::*;
#(
   parameter int NUM_COUNTERS = 16,
   parameter int WINDOW       = 4,
   parameter int CNT_BITS     = CWC_CNT_BITS
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             base_we_i,
   input  logic [7:0]                       base_wdata_i,
   input  logic [NUM_COUNTERS*CNT_BITS-1:0] snap_i,
   output logic [7:0]                       base_o,
   output logic [WINDOW*64-1:0]             win_data_o
);

   logic [7:0]           base_q;
   logic [WINDOW*64-1:0] win_q;
   logic [WINDOW*64-1:0] win_d;
   int                   sel_s;

   // Select each slot from the current bank and base; out-of-range slots read 0.
   always_comb begin
      win_d = '0;
      sel_s = 0;
      for (int w = 0; w < WINDOW; w++) begin
         sel_s = 32'(base_q) + w;
         if (sel_s < NUM_COUNTERS) begin
            win_d[w*64 +: 64] = 64'(snap_i[sel_s*CNT_BITS +: CNT_BITS]);
         end else begin
            win_d[w*64 +: 64] = 64'd0;
         end
      end
   end

   // Base register and registered window (one cycle behind bank/base changes).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q <= 8'd0;
         win_q  <= '0;
      end else begin
         if (base_we_i) begin
            base_q <= base_wdata_i;
         end
         win_q <= win_d;
      end
   end

   assign base_o     = base_q;
   assign win_data_o = win_q;

endmodule

// File: rtl/csr_counter_window_ctrl.sv
// csr_counter_window_ctrl
// Decodes host commands written to one CSR (SNAP, CLEAR, SET_WIN, CLR_ERR),
// sequentially snapshots NUM_COUNTERS live counters into a local bank, runs the
// clear handshake with the counter owners and publishes a window plus status.
// Optional feature macro: CSR_WIN_TIMESTAMP_EN (snapshot timestamp in status[63:32]).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en        : one-cycle command write strobe
//   wr_data      : command word, [7:0] opcode, [15:8] window base
//   cnt_in       : live counters, counter i at [i*CNT_BITS +: CNT_BITS]
//   cnt_freeze   : high while snapshotting
//   clr_req      : level clear request, dropped after clr_ack
//   clr_ack      : one-cycle clear acknowledge
//   win_data     : WINDOW x 64-bit counter window
//   status       : busy, error flags, base, snap_seq, optional timestamp
module csr_counter_window_ctrl
   import csr_counter_window_pkg::*;
#(
   parameter int NUM_COUNTERS = 16,
   parameter int WINDOW       = 4,
   parameter int CNT_BITS     = CWC_CNT_BITS
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             wr_en,
   input  logic [63:0]                      wr_data,
   input  logic [NUM_COUNTERS*CNT_BITS-1:0] cnt_in,
   output logic                             cnt_freeze,
   output logic                             clr_req,
   input  logic                             clr_ack,
   output logic [WINDOW*64-1:0]             win_data,
   output logic [63:0]                      status
);

   localparam int IDX_W = (NUM_COUNTERS > 2) ? $clog2(NUM_COUNTERS) : 1;

   t_cwc_state                       state_q, state_d;
   logic [IDX_W-1:0]                 idx_q;
   logic                             cnt_freeze_q, clr_req_q;
   logic [NUM_COUNTERS*CNT_BITS-1:0] snap_q;
   logic [15:0]                      snap_seq_q, snap_seq_d;
   logic                             err_drop_q, err_drop_d;
   logic                             err_badop_q, err_badop_d;
   logic                             err_badbase_q, err_badbase_d;
   logic [63:0]                      status_q, status_d;
   logic                             start_snap_s, start_clr_s, base_we_s;
   logic [7:0]                       base_q_s, base_d_s;
   logic [31:0]                      ts_hi_s;
   logic                             unused_wr_data_s;

   assign unused_wr_data_s = ^wr_data[63:16];

   // Command decode: accept/drop commands and compute sticky error flags.
   always_comb begin
      start_snap_s  = 1'b0;
      start_clr_s   = 1'b0;
      base_we_s     = 1'b0;
      err_drop_d    = err_drop_q;
      err_badop_d   = err_badop_q;
      err_badbase_d = err_badbase_q;
      if (wr_en) begin
         case (wr_data[7:0])
            OP_SNAP: begin
               if (state_q == CWC_IDLE) start_snap_s = 1'b1;
               else                     err_drop_d   = 1'b1;
            end
            OP_CLEAR: begin
               if (state_q == CWC_IDLE) start_clr_s = 1'b1;
               else                     err_drop_d  = 1'b1;
            end
            OP_SET_WIN: begin
               if (32'(wr_data[15:8]) < NUM_COUNTERS) base_we_s     = 1'b1;
               else                                   err_badbase_d = 1'b1;
            end
            OP_CLR_ERR: begin
               err_drop_d    = 1'b0;
               err_badop_d   = 1'b0;
               err_badbase_d = 1'b0;
            end
            default: err_badop_d = 1'b1;
         endcase
      end else begin
         start_snap_s = 1'b0;
      end
   end

   // Next-state logic; snap_seq advances as the last counter is copied.
   always_comb begin
      state_d    = state_q;
      snap_seq_d = snap_seq_q;
      case (state_q)
         CWC_IDLE: begin
            if (start_snap_s)     state_d = CWC_SNAP;
            else if (start_clr_s) state_d = CWC_CLR_WAIT;
            else                  state_d = CWC_IDLE;
         end
         CWC_SNAP: begin
            if (idx_q == IDX_W'(NUM_COUNTERS - 1)) begin
               state_d    = CWC_IDLE;
               snap_seq_d = snap_seq_q + 16'd1;
            end else begin
               state_d = CWC_SNAP;
            end
         end
         CWC_CLR_WAIT: begin
            if (clr_ack) state_d = CWC_IDLE;
            else         state_d = CWC_CLR_WAIT;
         end
         default: state_d = CWC_IDLE;
      endcase
   end

   assign base_d_s = base_we_s ? wr_data[15:8] : base_q_s;

`ifdef CSR_WIN_TIMESTAMP_EN
   logic [39:0] cycle_q;
   logic [39:0] ts_snap_q;
   logic [39:0] ts_snap_d;
   logic        unused_ts_s;

   assign ts_snap_d   = start_snap_s ? cycle_q : ts_snap_q;
   assign ts_hi_s     = ts_snap_d[39:8];
   assign unused_ts_s = ^ts_snap_d[7:0];

   // Free-running cycle counter and its capture on SNAP entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_q   <= 40'd0;
         ts_snap_q <= 40'd0;
      end else begin
         cycle_q   <= cycle_q + 40'd1;
         ts_snap_q <= ts_snap_d;
      end
   end
`else
   assign ts_hi_s = 32'd0;
`endif

   // Status word assembled from next-state values so it tracks the FSM exactly.
   always_comb begin
      status_d                         = 64'd0;
      status_d[ST_BUSY]                = (state_d != CWC_IDLE);
      status_d[ST_ERR_DROP]            = err_drop_d;
      status_d[ST_ERR_BADOP]           = err_badop_d;
      status_d[ST_ERR_BADBASE]         = err_badbase_d;
      status_d[ST_BASE_LSB +: 8]       = base_d_s;
      status_d[ST_SEQ_LSB +: 16]       = snap_seq_d;
      status_d[ST_TS_LSB +: 32]        = ts_hi_s;
   end

   // Controller FSM with registered outputs and the snapshot bank.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= CWC_IDLE;
         idx_q         <= '0;
         cnt_freeze_q  <= 1'b0;
         clr_req_q     <= 1'b0;
         snap_q        <= '0;
         snap_seq_q    <= 16'd0;
         err_drop_q    <= 1'b0;
         err_badop_q   <= 1'b0;
         err_badbase_q <= 1'b0;
         status_q      <= 64'd0;
      end else begin
         state_q       <= state_d;
         cnt_freeze_q  <= (state_d == CWC_SNAP);
         clr_req_q     <= (state_d == CWC_CLR_WAIT);
         snap_seq_q    <= snap_seq_d;
         err_drop_q    <= err_drop_d;
         err_badop_q   <= err_badop_d;
         err_badbase_q <= err_badbase_d;
         status_q      <= status_d;
         if (start_snap_s) begin
            idx_q <= '0;
         end else if (state_q == CWC_SNAP) begin
            idx_q <= idx_q + IDX_W'(1);
         end
         if (state_q == CWC_SNAP) begin
            snap_q[idx_q*CNT_BITS +: CNT_BITS] <= cnt_in[idx_q*CNT_BITS +: CNT_BITS];
         end
      end
   end

   csr_counter_window_mux #(
      .NUM_COUNTERS (NUM_COUNTERS),
      .WINDOW       (WINDOW),
      .CNT_BITS     (CNT_BITS)
   ) u_mux (
      .clk          (clk),
      .reset_n      (reset_n),
      .base_we_i    (base_we_s),
      .base_wdata_i (wr_data[15:8]),
      .snap_i       (snap_q),
      .base_o       (base_q_s),
      .win_data_o   (win_data)
   );

   assign cnt_freeze = cnt_freeze_q;
   assign clr_req    = clr_req_q;
   assign status     = status_q;

endmodule
